// File: rtl/spi_master_cmd_if.sv
// Request/response bus between a host controller and spi_master_cmd.
// The host drives requests; the SPI master answers with ready and responses.
interface spi_master_cmd_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    // Host side: issues requests, consumes responses.
    modport master (
        output req_valid,
        output req_wr,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    // SPI master side: accepts requests, produces responses.
    modport slave (
        input  req_valid,
        input  req_wr,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/spi_master_cmd.sv
// SPI mode-0 master issuing one 56-bit register frame per request:
// cmd[7:0] (0x02 write / 0x03 read), addr[15:0], data[31:0], MSB first.
// The last 32 MISO bits of each frame are returned on rsp_rdata.
module spi_master_cmd #(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rstn,
    spi_master_cmd_if.slave bus,
    output logic            spi_sck,
    output logic            spi_ss_n,
    output logic            spi_mosi,
    input  logic            spi_miso
);

    if (CLK_DIV < 2) begin : g_div_check
        $error("spi_master_cmd: CLK_DIV must be at least 2");
    end

    // Divider counter must reach 2*CLK_DIV-1 for the hold phase.
    localparam int DIV_W = (CLK_DIV >= 2) ? $clog2(2 * CLK_DIV) : 2;

    localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(32'd0);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    // Hold spans the trailing low half-period after the last SCK fall plus
    // the CLK_DIV hold itself, so ss_n rises 114*CLK_DIV after accept.
    localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(2 * CLK_DIV - 1);
    // Gap is one cycle shorter than CLK_DIV because the accepting edge in
    // IDLE completes the CLK_DIV cycles of ss_n high time.
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CLK_DIV - 2);

    localparam logic [7:0] CMD_WR   = 8'h02;
    localparam logic [7:0] CMD_RD   = 8'h03;
    localparam logic [5:0] LAST_BIT = 6'd55;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [5:0]       bit_q;
    logic [54:0]      tx_q;      // bits still to send after the one on MOSI
    logic [31:0]      rx_q;
    logic             sck_q;
    logic             ss_n_q;
    logic             mosi_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic [55:0]      frame_d;

    // Frame image built from the request fields; read frames send zero data.
    assign frame_d = bus.req_wr ? {CMD_WR, bus.req_addr, bus.req_wdata}
                                : {CMD_RD, bus.req_addr, 32'h0000_0000};

    // Frame sequencer: divider, bit counter, shift registers and all outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            div_q       <= DIV_ZERO;
            bit_q       <= 6'd0;
            tx_q        <= 55'd0;
            rx_q        <= 32'd0;
            sck_q       <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        tx_q    <= frame_d[54:0];
                        mosi_q  <= frame_d[55];
                        ss_n_q  <= 1'b0;
                        div_q   <= DIV_ZERO;
                        bit_q   <= 6'd0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_q == HALF_LAST) begin
                        div_q   <= DIV_ZERO;
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[30:0], spi_miso};
                        state_q <= ST_SHIFT;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (div_q == HALF_LAST) begin
                        div_q <= DIV_ZERO;
                        if (sck_q) begin
                            // Falling edge: advance MOSI unless this was bit 55.
                            sck_q <= 1'b0;
                            if (bit_q == LAST_BIT) begin
                                state_q <= ST_HOLD;
                            end else begin
                                bit_q  <= bit_q + 6'd1;
                                mosi_q <= tx_q[54];
                                tx_q   <= {tx_q[53:0], 1'b0};
                            end
                        end else begin
                            // Rising edge: sample MISO on the same clk edge.
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[30:0], spi_miso};
                        end
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                ST_HOLD: begin
                    if (div_q == HOLD_LAST) begin
                        div_q       <= DIV_ZERO;
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rx_q;
                        state_q     <= ST_GAP;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                ST_GAP: begin
                    if (div_q == GAP_LAST) begin
                        div_q   <= DIV_ZERO;
                        state_q <= ST_IDLE;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    div_q   <= DIV_ZERO;
                    sck_q   <= 1'b0;
                    ss_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign spi_sck       = sck_q;
    assign spi_ss_n      = ss_n_q;
    assign spi_mosi      = mosi_q;

endmodule
